// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the I2C TX FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 32'sd64;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after (owner+1) mod NREQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int OW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   owner,
  output logic [OW-1:0]   pick,
  output logic            valid
);

  localparam logic [OW-1:0] LAST = OW'(NREQ - 1);
  localparam logic [OW-1:0] ONE  = OW'(1);
  localparam logic [OW:0]   WRAP = (OW+1)'(NREQ);

  logic [OW-1:0]   start;
  logic [NREQ-1:0] rotated;
  logic [OW-1:0]   enc;
  logic [OW:0]     sum;

  // rotate so the highest-priority requester lands at bit 0, encode, rotate back
  always_comb begin
    start   = (owner == LAST) ? '0 : owner + ONE;
    rotated = NREQ'({req, req} >> start);
    enc     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        enc = OW'(i);
      end else begin
        enc = enc;
      end
    end
    sum = {1'b0, enc} + {1'b0, start};
    if (sum >= WRAP) begin
      pick = OW'(sum - WRAP);
    end else begin
      pick = sum[OW-1:0];
    end
    valid = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin write arbiter in front of the I2C-master TX FIFO.
// Optional stalled-owner release is enabled by defining ARB_IDLE_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32
`ifdef ARB_IDLE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*DWIDTH-1:0]    req_data,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           ack,
  output logic                      fifo_wr_en,
  output logic [DWIDTH-1:0]         fifo_data_in,
  input  logic                      fifo_full,
  output logic                      busy,
  output logic [clog2(NREQ)-1:0]    owner,
  output logic                      timeout
);

  localparam int OW = clog2(NREQ);
  localparam logic [OW-1:0] LAST = OW'(NREQ - 1);

  state_t          state, state_next;
  logic [NREQ-1:0] gnt_next;
  logic [OW-1:0]   owner_next;
  logic            busy_next;
  logic            timeout_next;
  logic [OW-1:0]   pick;
  logic            pick_valid;
  logic            tmo_fire;
  logic            accept;
  logic [DWIDTH-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*DWIDTH +: DWIDTH];
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req),
    .owner (owner),
    .pick  (pick),
    .valid (pick_valid)
  );

`ifdef ARB_IDLE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] idle_cnt;

  assign tmo_fire = (state == ST_LOCK) & ~req[owner] & (idle_cnt == TMO_LAST);

  // count owner-silent LOCK cycles; zero everywhere else so LOCK entry starts clean
  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_cnt <= 8'd0;
    end else if ((state != ST_LOCK) || req[owner]) begin
      idle_cnt <= 8'd0;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // owner's write path; only the owner can ever see an ack
  always_comb begin
    fifo_wr_en   = 1'b0;
    ack          = '0;
    fifo_data_in = '0;
    if (state == ST_LOCK) begin
      fifo_wr_en   = req[owner] & ~fifo_full;
      ack[owner]   = req[owner] & ~fifo_full;
      fifo_data_in = words[owner];
    end else begin
      fifo_wr_en   = 1'b0;
    end
  end

  assign accept = fifo_wr_en & req_last[owner];

  // next-state and next registered outputs
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    owner_next   = owner;
    busy_next    = busy;
    timeout_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next     = ST_LOCK;
          gnt_next       = '0;
          gnt_next[pick] = 1'b1;
          owner_next     = pick;
          busy_next      = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (accept || tmo_fire) begin
          state_next   = ST_IDLE;
          gnt_next     = '0;
          busy_next    = 1'b0;
          timeout_next = tmo_fire;
        end else begin
          state_next = ST_LOCK;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      owner   <= LAST;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      owner   <= owner_next;
      busy    <= busy_next;
      timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DWIDTH=32).
module tb_fifo_wr_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [3:0]   ack;
  logic         fifo_wr_en;
  logic [31:0]  fifo_data_in;
  logic         fifo_full;
  logic         busy;
  logic [1:0]   owner;
  logic         timeout;

  int n_cmp;
  int n_err;

  fifo_wr_arbiter #(
    .NREQ    (4),
    .DWIDTH  (32)
`ifdef ARB_IDLE_TIMEOUT_EN
    ,
    .TIMEOUT (8)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_last     (req_last),
    .req_data     (req_data),
    .gnt          (gnt),
    .ack          (ack),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .owner        (owner),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // new inputs 1 time unit after the edge, outputs sampled 2 units later
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic f);
    @(posedge clock);
    #1;
    req = r;
    req_last = l;
    fifo_full = f;
    #2;
  endtask

  initial begin
    logic saw_tmo;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    req = 4'b0000;
    req_last = 4'b0000;
    fifo_full = 1'b0;
    req_data = {word_of(3), word_of(2), word_of(1), word_of(0)};

    // reset state
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h3);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    reset = 1'b1;

    // test 1: req=0101 -> requester 0 first, 3-word packet, then requester 2
    step(4'b0101, 4'b0000, 1'b0);
    check("t1_idle_gnt", 32'(gnt), 32'h0);
    check("t1_idle_data", fifo_data_in, 32'h0);
    step(4'b0101, 4'b0000, 1'b0);
    check("t1_gnt0", 32'(gnt), 32'h1);
    check("t1_ack_w1", 32'(ack), 32'h1);
    check("t1_data_w1", fifo_data_in, word_of(0));
    step(4'b0101, 4'b0000, 1'b0);
    check("t1_ack_w2", 32'(ack), 32'h1);
    step(4'b0101, 4'b0001, 1'b0);
    check("t1_ack_w3", 32'(ack), 32'h1);
    check("t1_wr_w3", 32'(fifo_wr_en), 32'h1);
    step(4'b0100, 4'b0000, 1'b0);
    check("t1_rel_gnt", 32'(gnt), 32'h0);
    check("t1_rel_busy", 32'(busy), 32'h0);
    check("t1_rel_ack", 32'(ack), 32'h0);
    step(4'b0100, 4'b0100, 1'b0);
    check("t1_gnt2", 32'(gnt), 32'h4);
    check("t1_owner2", 32'(owner), 32'h2);
    check("t1_data2", fifo_data_in, word_of(2));

    // single requester re-grant, and test 4: non-owner req[1] never acked
    step(4'b0100, 4'b0000, 1'b0);
    check("t4_idle_gnt", 32'(gnt), 32'h0);
    step(4'b0110, 4'b0000, 1'b0);
    check("t4_regrant", 32'(gnt), 32'h4);
    check("t4_ack_own", 32'(ack), 32'h4);
    step(4'b0010, 4'b0000, 1'b0);
    check("t4_drop_gnt", 32'(gnt), 32'h4);
    check("t4_drop_ack", 32'(ack), 32'h0);
    check("t4_drop_wr", 32'(fifo_wr_en), 32'h0);
    step(4'b0110, 4'b0100, 1'b0);
    check("t4_last_ack", 32'(ack), 32'h4);
    step(4'b0010, 4'b0000, 1'b0);
    check("t4_rel_ack", 32'(ack), 32'h0);
    step(4'b0010, 4'b0000, 1'b0);
    check("t4_gnt1", 32'(gnt), 32'h2);
    check("t4_ack1", 32'(ack), 32'h2);
    step(4'b0010, 4'b0010, 1'b0);
    check("t4_ack1_last", 32'(ack), 32'h2);

    // test 2: wrap from owner 3 to requester 0
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    check("t2_gnt3", 32'(gnt), 32'h8);
    step(4'b1001, 4'b0000, 1'b0);
    check("t2_owner3", 32'(owner), 32'h3);
    step(4'b1001, 4'b0000, 1'b0);
    check("t2_wrap_gnt", 32'(gnt), 32'h1);
    check("t2_wrap_owner", 32'(owner), 32'h0);

    // test 3: FIFO full for 5 cycles mid-packet
    for (int i = 0; i < 5; i++) begin
      step(4'b1001, 4'b0000, 1'b1);
      check("t3_full_wr", 32'(fifo_wr_en), 32'h0);
      check("t3_full_ack", 32'(ack), 32'h0);
      check("t3_full_gnt", 32'(gnt), 32'h1);
    end
    step(4'b1001, 4'b0001, 1'b0);
    check("t3_resume_wr", 32'(fifo_wr_en), 32'h1);
    check("t3_resume_ack", 32'(ack), 32'h1);

    // test 5: reset on the 2nd word of a packet from requester 1
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    check("t5_gnt1", 32'(gnt), 32'h2);
    step(4'b0010, 4'b0000, 1'b0);
    check("t5_w2_ack", 32'(ack), 32'h2);
    reset = 1'b0;
    step(4'b0000, 4'b0000, 1'b0);
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_owner", 32'(owner), 32'h3);
    reset = 1'b1;

    // test 6: owner goes silent
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    check("t6_gnt0", 32'(gnt), 32'h1);
`ifdef ARB_IDLE_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 4'b0000, 1'b0);
      check("t6_hold_gnt", 32'(gnt), 32'h1);
      check("t6_hold_tmo", 32'(timeout), 32'h0);
    end
    step(4'b0000, 4'b0000, 1'b0);
    check("t6_tmo_pulse", 32'(timeout), 32'h1);
    check("t6_tmo_gnt", 32'(gnt), 32'h0);
    check("t6_tmo_busy", 32'(busy), 32'h0);
    step(4'b0000, 4'b0000, 1'b0);
    check("t6_tmo_end", 32'(timeout), 32'h0);
`else
    saw_tmo = 1'b0;
    for (int i = 0; i < 110; i++) begin
      step(4'b0000, 4'b0000, 1'b0);
      saw_tmo = saw_tmo | timeout | ~gnt[0];
    end
    check("t6_no_release", 32'(saw_tmo), 32'h0);
    check("t6_hold_gnt", 32'(gnt), 32'h1);
    check("t6_hold_busy", 32'(busy), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
